// File: rtl/pkg_en.sv
// Shared types for the ring-buffer drain controller and its stall-aware output register.
package pkg_en;

  typedef logic [31:0] FTk_t;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } state_t;

endpackage

// File: rtl/ring_buff_drain_oreg.sv
// Stall-aware output holding register: captures a token when enabled, clears when
// advancing without a capture, and holds everything while the downstream stalls.
module ring_buff_drain_oreg
  import pkg_en::*;
#(
  parameter type TYPE_FWRD = FTk_t
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     cap_en,
  input  logic     adv,
  input  TYPE_FWRD cap_data,
  output TYPE_FWRD tok,
  output logic     tok_valid
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tok       <= '0;
      tok_valid <= 1'b0;
    end else if (adv) begin
      if (cap_en) begin
        tok       <= cap_data;
        tok_valid <= 1'b1;
      end else begin
        tok       <= '0;
        tok_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ring_buff_drain.sv
// Reader-side controller for a ring-control buffer: issues read-enables in bursts or
// flush drains and forwards the read data through a nack-stallable output register.
module ring_buff_drain
  import pkg_en::*;
#(
  parameter int  DEPTH_BUFF  = 16,
  parameter int  WIDTH_DEPTH = $clog2(DEPTH_BUFF),
  parameter int  BURST_LEN   = 4,
  parameter type TYPE_FWRD   = FTk_t
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Empty,
  input  logic [WIDTH_DEPTH:0] I_Num,
  input  TYPE_FWRD             I_FTk,
  output logic                 O_Re,
  input  logic                 I_Flush,
  input  logic                 I_Nack,
  output TYPE_FWRD             O_FTk,
  output logic                 O_Valid,
  output logic                 O_Busy,
  output logic                 O_BurstDone,
  output logic                 O_FlushDone
);

  if (BURST_LEN < 1 || BURST_LEN > DEPTH_BUFF) begin : gen_bad_burst_len
    $error("BURST_LEN must lie in 1..DEPTH_BUFF");
  end

  localparam int                    CntW     = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0]       CntLoad  = CntW'(BURST_LEN);
  localparam logic [CntW-1:0]       CntOne   = CntW'(1);
  localparam logic [WIDTH_DEPTH:0]  BurstNum = (WIDTH_DEPTH + 1)'(BURST_LEN);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic            adv;
  logic            rd_en;

  assign adv   = !O_Valid || !I_Nack;
  assign rd_en = adv && !I_Empty && (state_q == BURST || state_q == FLUSH);
  assign O_Re  = rd_en;
  assign O_Busy = (state_q != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q || I_Flush;
    O_BurstDone  = 1'b0;
    O_FlushDone  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_pend_q || I_Flush) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
        end else if (I_Num >= BurstNum) begin
          state_d = BURST;
          cnt_d   = CntLoad;
        end
      end
      BURST: begin
        // An empty buffer only pauses the burst; it finishes once all reads are issued.
        if (rd_en) begin
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            O_BurstDone = 1'b1;
            if (flush_pend_d) begin
              state_d      = FLUSH;
              flush_pend_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        if (I_Empty && !rd_en) begin
          O_FlushDone  = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  ring_buff_drain_oreg #(
    .TYPE_FWRD(TYPE_FWRD)
  ) u_oreg (
    .clock    (clock),
    .reset    (reset),
    .cap_en   (rd_en),
    .adv      (adv),
    .cap_data (I_FTk),
    .tok      (O_FTk),
    .tok_valid(O_Valid)
  );

endmodule

// File: tb/tb_ring_buff_drain.sv
// Scoreboard bench: a queue models the buffer, expected tokens are queued on write and
// a negedge monitor pops and compares every token the downstream accepts.
module tb_ring_buff_drain;
  import pkg_en::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       I_Empty, I_Flush, I_Nack;
  logic [4:0] I_Num;
  FTk_t       I_FTk, O_FTk;
  logic       O_Re, O_Valid, O_Busy, O_BurstDone, O_FlushDone;

  int   total = 0;
  int   bad = 0;
  int   n_re = 0, n_bd = 0, n_fd = 0;
  logic re_seen = 1'b0;
  FTk_t bufq[$];
  FTk_t expq[$];
  FTk_t dv[8];

  always #5 clock = ~clock;

  ring_buff_drain u_dut (
    .clock      (clock),
    .reset      (reset),
    .I_Empty    (I_Empty),
    .I_Num      (I_Num),
    .I_FTk      (I_FTk),
    .O_Re       (O_Re),
    .I_Flush    (I_Flush),
    .I_Nack     (I_Nack),
    .O_FTk      (O_FTk),
    .O_Valid    (O_Valid),
    .O_Busy     (O_Busy),
    .O_BurstDone(O_BurstDone),
    .O_FlushDone(O_FlushDone)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic update_bus();
    I_Num   = 5'(bufq.size());
    I_Empty = (bufq.size() == 0);
    I_FTk   = (bufq.size() != 0) ? bufq[0] : '0;
  endtask

  task automatic push(input FTk_t d);
    bufq.push_back(d);
    expq.push_back(d);
    update_bus();
  endtask

  // Advance one clock; the buffer pops on the edge where the DUT asserted a read.
  task automatic tick();
    @(posedge clock);
    #1;
    if (re_seen && bufq.size() != 0) bufq.delete(0);
    I_Flush = 1'b0;
    update_bus();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int ctr(input int which);
    case (which)
      0:       return n_re;
      1:       return n_bd;
      default: return n_fd;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int target);
    int budget = 200;
    while (ctr(which) < target && budget > 0) begin
      tick();
      budget--;
    end
    if (ctr(which) < target) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, count %0d, want %0d", name, ctr(which), target);
    end
  endtask

  // Monitor: invariants plus token scoreboard on every accepted output.
  initial forever begin
    @(negedge clock);
    re_seen = O_Re;
    if (reset) begin
      if (O_Re) n_re++;
      chk("re_while_empty", 64'(O_Re && I_Empty), 64'(0));
      if (!O_Valid) chk("ftk_zero_when_invalid", 64'(O_FTk), 64'(0));
      if (O_BurstDone) begin
        n_bd++;
        chk("burstdone_with_read", 64'(O_Re), 64'(1));
      end
      if (O_FlushDone) begin
        n_fd++;
        chk("flushdone_when_empty", 64'(I_Empty), 64'(1));
      end
      if (O_Valid && !I_Nack) begin
        if (expq.size() == 0) begin
          chk("token_unexpected", 64'(O_FTk), 64'hffff_ffff_ffff_ffff);
        end else begin
          chk("token", 64'(O_FTk), 64'(expq[0]));
          expq.delete(0);
        end
      end
    end
  end

  initial begin
    int b_re, b_bd, b_fd;
    I_Flush = 1'b0;
    I_Nack  = 1'b0;
    update_bus();
    for (int i = 0; i < 8; i++) dv[i] = $urandom;

    // Reset state
    #12;
    chk("rst_re", 64'(O_Re), 64'(0));
    chk("rst_valid", 64'(O_Valid), 64'(0));
    chk("rst_ftk", 64'(O_FTk), 64'(0));
    chk("rst_busy", 64'(O_Busy), 64'(0));
    chk("rst_bd", 64'(O_BurstDone), 64'(0));
    chk("rst_fd", 64'(O_FlushDone), 64'(0));
    @(posedge clock);
    #1 reset = 1'b1;

    // Burst trigger: 3 entries do nothing, the 4th starts a burst
    for (int i = 1; i <= 3; i++) push(FTk_t'(i));
    ticks(5);
    chk("below_thresh_reads", 64'(n_re), 64'(0));
    chk("below_thresh_busy", 64'(O_Busy), 64'(0));
    b_re = n_re; b_bd = n_bd;
    push(FTk_t'(4));
    wait_for("burst1", 1, b_bd + 1);
    ticks(3);
    chk("burst1_reads", 64'(n_re - b_re), 64'(4));
    chk("burst1_num", 64'(I_Num), 64'(0));
    chk("burst1_idle", 64'(O_Busy), 64'(0));

    // Stall: nack for 4 cycles while the 2nd token sits in the output register
    b_re = n_re; b_bd = n_bd;
    for (int i = 0; i < 8; i++) push(dv[i]);
    wait_for("stall_2reads", 0, b_re + 2);
    I_Nack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_no_read", 64'(O_Re), 64'(0));
      chk("stall_hold", 64'(O_FTk), 64'(dv[1]));
      tick();
    end
    I_Nack = 1'b0;
    wait_for("stall_burst", 1, b_bd + 1);
    chk("stall_reads", 64'(n_re - b_re), 64'(4));
    chk("stall_left", 64'(I_Num), 64'(4));
    tick();
    chk("second_burst_busy", 64'(O_Busy), 64'(1));
    wait_for("second_burst", 1, b_bd + 2);
    ticks(3);
    chk("stall_all_read", 64'(I_Num), 64'(0));

    // Empty mid-burst: two entries vanish, the burst waits and resumes
    b_re = n_re; b_bd = n_bd;
    for (int i = 0; i < 4; i++) push($urandom);
    wait_for("emb_2reads", 0, b_re + 2);
    bufq.delete();
    void'(expq.pop_back());
    void'(expq.pop_back());
    update_bus();
    ticks(3);
    chk("emb_busy", 64'(O_Busy), 64'(1));
    chk("emb_paused", 64'(n_re - b_re), 64'(2));
    chk("emb_no_bd", 64'(n_bd - b_bd), 64'(0));
    push($urandom);
    push($urandom);
    wait_for("emb_burst", 1, b_bd + 1);
    chk("emb_reads", 64'(n_re - b_re), 64'(4));
    ticks(3);

    // Flush of 3 entries
    b_re = n_re; b_fd = n_fd;
    for (int i = 0; i < 3; i++) push($urandom);
    I_Flush = 1'b1;
    wait_for("flush3", 2, b_fd + 1);
    chk("flush3_reads", 64'(n_re - b_re), 64'(3));
    chk("flush3_idle", 64'(O_Busy), 64'(0));

    // Flush with an empty buffer: one FLUSH cycle, then done
    ticks(2);
    I_Flush = 1'b1;
    tick();
    chk("flush_empty_busy", 64'(O_Busy), 64'(1));
    chk("flush_empty_done", 64'(O_FlushDone), 64'(1));
    tick();
    chk("flush_empty_idle", 64'(O_Busy), 64'(0));

    // Flush collides with the burst-final read
    ticks(2);
    b_re = n_re; b_bd = n_bd; b_fd = n_fd;
    for (int i = 0; i < 6; i++) push($urandom);
    wait_for("coll_3reads", 0, b_re + 3);
    I_Flush = 1'b1;
    #1;
    chk("coll_bd", 64'(O_BurstDone), 64'(1));
    wait_for("coll_flush", 2, b_fd + 1);
    chk("coll_reads", 64'(n_re - b_re), 64'(6));
    chk("coll_bd_count", 64'(n_bd - b_bd), 64'(1));
    tick();
    chk("coll_idle", 64'(O_Busy), 64'(0));

    // Asynchronous reset mid-burst
    ticks(2);
    b_re = n_re;
    for (int i = 0; i < 8; i++) push($urandom);
    wait_for("ar_2reads", 0, b_re + 2);
    #2;
    if (O_Valid && expq.size() != 0) expq.delete(0);
    reset = 1'b0;
    #1;
    chk("ar_re", 64'(O_Re), 64'(0));
    chk("ar_valid", 64'(O_Valid), 64'(0));
    chk("ar_busy", 64'(O_Busy), 64'(0));
    void'(bufq.pop_back());
    void'(expq.pop_back());
    update_bus();
    chk("ar_num", 64'(I_Num), 64'(5));
    @(posedge clock);
    #1 reset = 1'b1;
    b_re = n_re; b_bd = n_bd;
    wait_for("ar_burst", 1, b_bd + 1);
    chk("ar_reads", 64'(n_re - b_re), 64'(4));
    chk("ar_left", 64'(I_Num), 64'(1));
    b_fd = n_fd;
    tick();
    I_Flush = 1'b1;
    wait_for("ar_flush", 2, b_fd + 1);

    // Randomized traffic: pushes, stalls and flush requests
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (bufq.size() < 14 && $urandom_range(99) < 40) push($urandom);
      I_Nack  = ($urandom_range(99) < 30);
      I_Flush = ($urandom_range(99) < 3);
    end
    I_Nack = 1'b0;
    tick();
    I_Flush = 1'b1;
    begin
      int budget = 300;
      while ((expq.size() != 0 || O_Busy || O_Valid) && budget > 0) begin
        tick();
        budget--;
      end
    end
    chk("final_tokens_left", 64'(expq.size()), 64'(0));
    chk("final_busy", 64'(O_Busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
